// File: rtl/picosoc_timer.sv
// -----------------------------------------------------------------------------
// picosoc_timer
// Down-counting timer/interrupt peripheral for the PicoSoC iomem bus.
// The block decodes its own address window (iomem_addr[31:24] == BASE_SEL) and
// answers each transaction with a one-cycle registered ready. When the counter
// expires, the sticky STATUS.EXP flag is set. irq_out is the level interrupt
// STATUS.EXP & CTRL.IRQ_EN.
//
// Register map (offset = iomem_addr[4:2]*4), all writes honour byte strobes:
//   0x00 CTRL      [0]EN [1]AUTO_RELOAD [2]IRQ_EN
//   0x04 PRESCALE  [PRESCALE_W-1:0]
//   0x08 RELOAD    [31:0]
//   0x0C COUNT     [31:0]  (a write loads the counter)
//   0x10 STATUS    [0]EXP  (write 1 clears)
//   0x14..0x1C     read 0, writes ignored
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   iomem_valid  bus request valid
//   iomem_ready  one-cycle acknowledge, the cycle after the request is taken
//   iomem_wstrb  byte write strobes, 4'b0000 = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready = 1
//   irq_out      level interrupt
// -----------------------------------------------------------------------------
module picosoc_timer #(
  parameter logic [7:0] BASE_SEL   = 8'h04,
  parameter int         PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_RELOAD   = 3'd2,
    REG_COUNT    = 3'd3,
    REG_STATUS   = 3'd4
  } reg_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Architectural state
  logic                  r_en;
  logic                  r_auto;
  logic                  r_irq_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [31:0]           r_reload;
  logic [31:0]           r_count;
  logic                  r_exp;
  logic                  r_ready;
  logic [31:0]           r_rdata;

  // Bus decode
  logic        w_sel;
  logic        w_wr;
  reg_e        w_reg;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_wr_reload;
  logic        w_wr_count;
  logic        w_wr_status;
  logic [31:0] w_pre_merged;
  logic [31:0] w_rd_mux;

  // Timer events
  logic        w_tick;
  logic        w_expire;

  // The !r_ready term makes every request take two cycles: the request cycle
  // and the acknowledge cycle, during which the same request is ignored.
  assign w_sel = iomem_valid && (iomem_addr[31:24] == BASE_SEL) && !r_ready;
  assign w_wr  = w_sel && (iomem_wstrb != 4'b0000);
  assign w_reg = reg_e'(iomem_addr[4:2]);

  // CTRL and STATUS only have bits in byte 0, so only that strobe matters.
  assign w_wr_ctrl    = w_wr && (w_reg == REG_CTRL) && iomem_wstrb[0];
  assign w_wr_pre     = w_wr && (w_reg == REG_PRESCALE);
  assign w_wr_reload  = w_wr && (w_reg == REG_RELOAD);
  assign w_wr_count   = w_wr && (w_reg == REG_COUNT);
  assign w_wr_status  = w_wr && (w_reg == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0];
  assign w_pre_merged = merge_bytes(32'(r_prescale), iomem_wdata, iomem_wstrb);

  assign w_tick   = r_en && (r_pcnt == r_prescale);
  // A bus write to COUNT in the same cycle overrides the tick entirely,
  // including any expiry it would have caused.
  assign w_expire = w_tick && (r_count == 32'd0) && !w_wr_count;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_reg)
      REG_CTRL:     w_rd_mux = {29'd0, r_irq_en, r_auto, r_en};
      REG_PRESCALE: w_rd_mux = 32'(r_prescale);
      REG_RELOAD:   w_rd_mux = r_reload;
      REG_COUNT:    w_rd_mux = r_count;
      REG_STATUS:   w_rd_mux = {31'd0, r_exp};
      default:      w_rd_mux = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every right-hand
  // side below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_reload   <= 32'd0;
      r_count    <= 32'd0;
      r_exp      <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_ready <= w_sel;
      // Read data is captured in the request cycle, so a write returns the
      // value the register held before the write.
      if (w_sel) r_rdata <= w_rd_mux;

      // Prescaler: restart on disable, on any PRESCALE write, and after each tick.
      if (!r_en || w_wr_pre || w_tick) r_pcnt <= '0;
      else                             r_pcnt <= r_pcnt + PRESCALE_W'(1);

      if (w_wr_pre)    r_prescale <= w_pre_merged[PRESCALE_W-1:0];
      if (w_wr_reload) r_reload   <= merge_bytes(r_reload, iomem_wdata, iomem_wstrb);

      // Counter: a reload uses the pre-edge RELOAD, so a RELOAD write in the
      // same cycle only takes effect for the following period.
      if (w_wr_count) begin
        r_count <= merge_bytes(r_count, iomem_wdata, iomem_wstrb);
      end else if (w_tick) begin
        if (r_count != 32'd0) r_count <= r_count - 32'd1;
        else if (r_auto)      r_count <= r_reload;
      end

      // A CTRL write wins over the one-shot self-disable.
      if (w_wr_ctrl) begin
        {r_irq_en, r_auto, r_en} <= iomem_wdata[2:0];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      // Setting the flag wins over a simultaneous clear.
      if (w_expire)         r_exp <= 1'b1;
      else if (w_wr_status) r_exp <= 1'b0;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq_out     = r_exp & r_irq_en;

endmodule
